// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage definitions: ALU/MD opcodes, ctrl_ex field positions,
// multiply/divide FSM states and the single-cycle ALU function.
package riscv_pkg;

  localparam int XLEN            = 32;
  localparam int CTRL_W          = 15;
  localparam int CTRL_MEM_W      = 5;
  localparam int CTRL_SRC_B      = 5;
  localparam int CTRL_SRC_A      = 6;
  localparam int CTRL_ALU_OP_LSB = 7;
  localparam int CTRL_MD_F3_LSB  = 11;
  localparam int CTRL_MD_EN      = 14;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_funct3_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Unassigned op codes (11-15) deliberately produce zero.
  function automatic logic [XLEN-1:0] alu_compute(alu_op_e op, logic [XLEN-1:0] a,
                                                  logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (op)
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_SLL:   r = a << b[4:0];
      ALU_SLT:   r = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  r = {31'd0, a < b};
      ALU_XOR:   r = a ^ b;
      ALU_SRL:   r = a >> b[4:0];
      ALU_SRA:   r = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:    r = a | b;
      ALU_AND:   r = a & b;
      ALU_PASSB: r = b;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M unit: 32 cycles of shift-add multiply or restoring divide on
// operand magnitudes, with the sign applied combinationally on the way out.
module muldiv_iter
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  md_funct3_e       funct3,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result
);

  md_funct3_e      f3_q;
  logic [XLEN-1:0] hi, lo, dvs;
  logic [4:0]      cnt;
  logic            neg_main, neg_rem;

  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign is_div   = funct3[2];
  assign a_signed = is_div ? !funct3[0] : (funct3 == MD_MULH || funct3 == MD_MULHSU);
  assign b_signed = is_div ? !funct3[0] : (funct3 == MD_MULH);
  assign a_neg    = a_signed && a[XLEN-1];
  assign b_neg    = b_signed && b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;

  // Multiply: {carry,hi,lo} shifts right, adding the multiplicand when lo[0] is set.
  // Divide: {hi,lo} shifts left, hi is the partial remainder, lo collects quotient bits.
  logic [XLEN:0] mul_sum, div_sh, div_diff;
  logic          div_ge;

  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
  assign div_sh   = {hi, lo[XLEN-1]};
  assign div_ge   = div_sh >= {1'b0, dvs};
  assign div_diff = div_sh - {1'b0, dvs};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f3_q     <= MD_MUL;
      hi       <= '0;
      lo       <= '0;
      dvs      <= '0;
      cnt      <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      f3_q     <= funct3;
      hi       <= '0;
      lo       <= a_mag;
      dvs      <= b_mag;
      cnt      <= '0;
      // A zero divisor keeps the all-ones quotient unsigned.
      neg_main <= (a_neg ^ b_neg) && !(is_div && b == '0);
      neg_rem  <= a_neg;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else if (busy) begin
      if (f3_q[2]) begin
        hi <= div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
        lo <= {lo[XLEN-2:0], div_ge};
      end else begin
        hi <= mul_sum[XLEN:1];
        lo <= {mul_sum[0], lo[XLEN-1:1]};
      end
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_main ? -{hi, lo} : {hi, lo};
  assign quo_fix  = neg_main ? -lo : lo;
  assign rem_fix  = neg_rem  ? -hi : hi;

  always_comb begin
    result = prod_fix[XLEN-1:0];
    case (f3_q)
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = quo_fix;
      MD_REM, MD_REMU:              result = rem_fix;
      default:                      result = prod_fix[XLEN-1:0];
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32 execute stage: single-cycle ALU plus EX/MEM output register.
// Define RV32M_EN to add the iterative multiply/divide unit with its stall FSM.
module execute_stage
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CTRL_W-1:0]     ctrl_ex,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [XLEN-1:0]       imm,
  input  logic [XLEN-1:0]       pc,
  input  logic [XLEN-1:0]       pc4_ex,
  input  logic [XLEN-1:0]       rd_ex,
  input  logic                  flush,
  output logic                  stall,
  output logic [CTRL_MEM_W-1:0] ctrl_mem,
  output logic [XLEN-1:0]       rd_mem,
  output logic [XLEN-1:0]       pc4_mem,
  output logic [XLEN-1:0]       alu_result,
  output logic [XLEN-1:0]       write_data1
);

  logic [XLEN-1:0] op_a, op_b, alu_out;

  assign op_a    = ctrl_ex[CTRL_SRC_A] ? pc  : rs1_data;
  assign op_b    = ctrl_ex[CTRL_SRC_B] ? imm : rs2_data;
  assign alu_out = alu_compute(alu_op_e'(ctrl_ex[CTRL_ALU_OP_LSB +: 4]), op_a, op_b);

`ifdef RV32M_EN
  md_state_e             state;
  logic [4:0]            run_cnt;
  logic                  md_start, md_busy, md_done;
  logic [XLEN-1:0]       md_result;
  logic [CTRL_MEM_W-1:0] h_ctrl;
  logic [XLEN-1:0]       h_rd, h_pc4, h_rs2;
  logic                  unused_md_status;

  assign md_start         = (state == MD_IDLE) && ctrl_ex[CTRL_MD_EN] && !flush;
  // Gated by reset_n so a pending md_en cannot raise stall while held in reset.
  assign stall            = reset_n && (md_start || (state == MD_RUN && !flush));
  assign unused_md_status = md_busy ^ md_done;

  muldiv_iter u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start),
    .funct3  (md_funct3_e'(ctrl_ex[CTRL_MD_F3_LSB +: 3])),
    .a       (rs1_data),
    .b       (rs2_data),
    .busy    (md_busy),
    .done    (md_done),
    .result  (md_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= MD_IDLE;
      run_cnt <= '0;
      h_ctrl  <= '0;
      h_rd    <= '0;
      h_pc4   <= '0;
      h_rs2   <= '0;
    end else if (flush) begin
      state   <= MD_IDLE;
      run_cnt <= '0;
    end else begin
      case (state)
        MD_IDLE: if (md_start) begin
          state   <= MD_RUN;
          run_cnt <= '0;
          h_ctrl  <= ctrl_ex[CTRL_MEM_W-1:0];
          h_rd    <= rd_ex;
          h_pc4   <= pc4_ex;
          h_rs2   <= rs2_data;
        end
        MD_RUN: begin
          if (run_cnt == 5'd31) begin
            state   <= MD_DONE;
            run_cnt <= '0;
          end else begin
            run_cnt <= run_cnt + 5'd1;
          end
        end
        MD_DONE: state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end
`else
  logic unused_md_ctrl;

  assign stall          = 1'b0;
  assign unused_md_ctrl = ^ctrl_ex[CTRL_MD_EN:CTRL_MD_F3_LSB];
`endif

  logic [CTRL_MEM_W-1:0] nxt_ctrl;
  logic [XLEN-1:0]       nxt_rd, nxt_pc4, nxt_res, nxt_wd;

  // NOTE: every output gets a default before any condition, so no path infers a latch.
  always_comb begin
    nxt_ctrl = ctrl_ex[CTRL_MEM_W-1:0];
    nxt_rd   = rd_ex;
    nxt_pc4  = pc4_ex;
    nxt_res  = alu_out;
    nxt_wd   = rs2_data;
`ifdef RV32M_EN
    if (state == MD_DONE) begin
      nxt_ctrl = h_ctrl;
      nxt_rd   = h_rd;
      nxt_pc4  = h_pc4;
      nxt_res  = md_result;
      nxt_wd   = h_rs2;
    end
`endif
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_mem    <= '0;
      rd_mem      <= '0;
      pc4_mem     <= '0;
      alu_result  <= '0;
      write_data1 <= '0;
    end else if (flush || stall) begin
      ctrl_mem <= '0;
    end else begin
      ctrl_mem    <= nxt_ctrl;
      rd_mem      <= nxt_rd;
      pc4_mem     <= nxt_pc4;
      alu_result  <= nxt_res;
      write_data1 <= nxt_wd;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed and random ALU/RV32M traffic
// compared against an arithmetic reference model of the EX/MEM register.
module tb_execute_stage;

  logic        clk, reset_n, flush, stall;
  logic [14:0] ctrl_ex;
  logic [31:0] rs1_data, rs2_data, imm, pc, pc4_ex, rd_ex;
  logic [4:0]  ctrl_mem;
  logic [31:0] rd_mem, pc4_mem, alu_result, write_data1;

  int errors = 0;
  int checks = 0;

  // Model of the output register contents.
  logic [4:0]  m_ctrl;
  logic [31:0] m_rd, m_pc4, m_res, m_wd;

  execute_stage dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ctrl_ex     (ctrl_ex),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm         (imm),
    .pc          (pc),
    .pc4_ex      (pc4_ex),
    .rd_ex       (rd_ex),
    .flush       (flush),
    .stall       (stall),
    .ctrl_mem    (ctrl_mem),
    .rd_mem      (rd_mem),
    .pc4_mem     (pc4_mem),
    .alu_result  (alu_result),
    .write_data1 (write_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, p2;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p2 = longint'(1) << b[4:0];
    case (op)
      4'd0:    t = ua + ub;
      4'd1:    t = ua - ub;
      4'd2:    t = ua * p2;
      4'd3:    t = (sa < sb) ? 64'd1 : 64'd0;
      4'd4:    t = (ua < ub) ? 64'd1 : 64'd0;
      4'd5:    t = {32'd0, a ^ b};
      4'd6:    t = ua / p2;
      4'd7:    t = sa >>> b[4:0];
      4'd8:    t = {32'd0, a | b};
      4'd9:    t = {32'd0, a & b};
      4'd10:   t = ub;
      default: t = 64'd0;
    endcase
    return t[31:0];
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        p = (b == 0 || ovf) ? 64'd0 : sa / sb;
        r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : p[31:0]);
      end
      3'd5: begin
        p = (b == 0) ? 64'd0 : ua / ub;
        r = (b == 0) ? 32'hFFFF_FFFF : p[31:0];
      end
      3'd6: begin
        p = (b == 0 || ovf) ? 64'd0 : sa % sb;
        r = (b == 0) ? a : (ovf ? 32'd0 : p[31:0]);
      end
      default: begin
        p = (b == 0) ? 64'd0 : ua % ub;
        r = (b == 0) ? a : p[31:0];
      end
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ctrl_mem"},    {27'd0, ctrl_mem}, {27'd0, m_ctrl});
    check({tag, ".rd_mem"},      rd_mem,      m_rd);
    check({tag, ".pc4_mem"},     pc4_mem,     m_pc4);
    check({tag, ".alu_result"},  alu_result,  m_res);
    check({tag, ".write_data1"}, write_data1, m_wd);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [14:0] c, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] im, input logic [31:0] p, input logic [31:0] p4,
                           input logic [31:0] rd);
    ctrl_ex  = c;
    rs1_data = r1;
    rs2_data = r2;
    imm      = im;
    pc       = p;
    pc4_ex   = p4;
    rd_ex    = rd;
    flush    = 1'b0;
  endtask

  // One non-md instruction: stall stays low and the result appears after one edge.
  task automatic alu_step(input string tag, input logic [14:0] c, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] im);
    logic [31:0] a, b, p, p4, rd;
    p  = $urandom;
    p4 = p + 32'd4;
    rd = $urandom_range(0, 31);
    set_instr(c, r1, r2, im, p, p4, rd);
    #1;
    check({tag, ".stall"}, {31'd0, stall}, 32'd0);
    a = c[6] ? p : r1;
    b = c[5] ? im : r2;
    tick;
    m_ctrl = c[4:0];
    m_rd   = rd;
    m_pc4  = p4;
    m_res  = alu_ref(c[10:7], a, b);
    m_wd   = r2;
    check_outputs(tag);
  endtask

  function automatic logic [14:0] rand_alu_ctrl();
    logic [14:0] c;
    c = 15'($urandom);
`ifdef RV32M_EN
    c[14] = 1'b0;
`endif
    return c;
  endfunction

`ifdef RV32M_EN
  // One md instruction held from cycle N through DONE; result lands after edge N+33.
  task automatic md_step(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b);
    logic [14:0] c;
    logic [31:0] p, p4, rd;
    int          stall_cycles;
    int          bubble_bad;
    c     = 15'($urandom);
    c[14] = 1'b1;
    c[13:11] = f;
    p  = $urandom;
    p4 = p + 32'd4;
    rd = $urandom_range(0, 31);
    set_instr(c, a, b, $urandom, p, p4, rd);
    #1;
    stall_cycles = stall ? 1 : 0;
    bubble_bad   = 0;
    for (int k = 1; k <= 32; k++) begin
      tick;
      m_ctrl = 5'd0;
      if (stall) stall_cycles++;
      if (ctrl_mem !== 5'd0 || rd_mem !== m_rd || alu_result !== m_res) bubble_bad++;
    end
    check({tag, ".stall_cycles"}, stall_cycles, 33);
    check({tag, ".bubbles"}, bubble_bad, 0);
    tick;
    check({tag, ".stall_done"}, {31'd0, stall}, 32'd0);
    check_outputs({tag, ".pre"});
    tick;
    m_ctrl = c[4:0];
    m_rd   = rd;
    m_pc4  = p4;
    m_res  = md_ref(f, a, b);
    m_wd   = b;
    check_outputs(tag);
  endtask
`endif

  initial begin
    m_ctrl = '0;
    m_rd   = '0;
    m_pc4  = '0;
    m_res  = '0;
    m_wd   = '0;
    reset_n = 1'b0;
    set_instr(15'h4abc, 32'd1, 32'd2, 32'd3, 32'd4, 32'd8, 32'd5);
    #1;
    check("reset.stall", {31'd0, stall}, 32'd0);
    check_outputs("reset");
    tick;
    tick;
    check_outputs("reset_hold");
    @(negedge clk);
    reset_n = 1'b1;
    tick;

    // ADD rs1=5 rs2=7 with ctrl bits 01010.
    alu_step("add_5_7", {1'b0, 3'd0, 4'd0, 2'b00, 5'b01010}, 32'd5, 32'd7, 32'd99);
    check("add_5_7.value", alu_result, 32'd12);
    alu_step("sra_imm", {1'b0, 3'd0, 4'd7, 2'b01, 5'b00001}, 32'h8000_0000, 32'd0, 32'd4);
    check("sra_imm.value", alu_result, 32'hF800_0000);
    alu_step("sltu", {1'b0, 3'd0, 4'd4, 2'b00, 5'b00011}, 32'd1, 32'hFFFF_FFFF, 32'd0);
    alu_step("slt", {1'b0, 3'd0, 4'd3, 2'b00, 5'b00011}, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_step("sub_wrap", {1'b0, 3'd0, 4'd1, 2'b00, 5'b00100}, 32'd0, 32'd1, 32'd0);
    alu_step("auipc", {1'b0, 3'd0, 4'd0, 2'b11, 5'b00101}, 32'd0, 32'd0, 32'h1000);
    alu_step("op_13", {1'b0, 3'd0, 4'd13, 2'b00, 5'b11111}, 32'd3, 32'd3, 32'd0);

    // Flush of an ALU instruction loads a bubble, other outputs hold.
    set_instr({1'b0, 3'd0, 4'd0, 2'b00, 5'b10101}, 32'd1, 32'd1, 32'd0, 32'd0, 32'd4, 32'd9);
    flush = 1'b1;
    #1;
    check("flush_alu.stall", {31'd0, stall}, 32'd0);
    tick;
    m_ctrl = 5'd0;
    check_outputs("flush_alu");

    for (int i = 0; i < 40; i++)
      alu_step("rand_alu", rand_alu_ctrl(), $urandom, $urandom, $urandom);

`ifdef RV32M_EN
    md_step("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    md_step("div_by0", 3'd4, 32'd7, 32'd0);
    md_step("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    md_step("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    md_step("divu_100_7", 3'd5, 32'd100, 32'd7);
    md_step("rem_by0", 3'd6, 32'hFFFF_FFF9, 32'd0);
    md_step("mulhsu", 3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    alu_step("after_md", {1'b0, 3'd0, 4'd0, 2'b00, 5'b01010}, 32'd20, 32'd22, 32'd0);
    for (int i = 0; i < 8; i++)
      md_step("rand_md", 3'($urandom), $urandom, (i == 3) ? 32'd0 : $urandom);

    // Flush at RUN count 10 abandons the operation.
    set_instr({1'b1, 3'd0, 4'd0, 2'b00, 5'b10001}, 32'd3, 32'd4, 32'd0, 32'd0, 32'd4, 32'd7);
    for (int k = 0; k < 11; k++) begin
      tick;
      m_ctrl = 5'd0;
    end
    check("flush_run.stall_before", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    #1;
    check("flush_run.stall", {31'd0, stall}, 32'd0);
    tick;
    check_outputs("flush_run");
    alu_step("post_flush_add", {1'b0, 3'd0, 4'd0, 2'b00, 5'b01100}, 32'd40, 32'd2, 32'd0);

    // Flush in IDLE beats an md start.
    set_instr({1'b1, 3'd4, 4'd0, 2'b00, 5'b00111}, 32'd9, 32'd3, 32'd0, 32'd0, 32'd4, 32'd2);
    flush = 1'b1;
    #1;
    check("flush_start.stall", {31'd0, stall}, 32'd0);
    tick;
    m_ctrl = 5'd0;
    check_outputs("flush_start");
    alu_step("post_flush2", {1'b0, 3'd0, 4'd5, 2'b00, 5'b00110}, 32'hF0F0, 32'h0FF0, 32'd0);
`else
    // md_en is ignored: the ALU op in ctrl_ex runs instead.
    alu_step("mul_as_add", {1'b1, 3'd0, 4'd0, 2'b00, 5'b01010}, 32'd3, 32'd4, 32'd0);
    check("mul_as_add.value", alu_result, 32'd7);
    alu_step("div_as_and", {1'b1, 3'd4, 4'd9, 2'b00, 5'b00010}, 32'hFF, 32'h0F, 32'd0);
`endif

    // Reset in the middle of an md operation (or with md_en asserted).
    set_instr({1'b1, 3'd5, 4'd0, 2'b00, 5'b11011}, 32'd1000, 32'd3, 32'd0, 32'd0, 32'd4, 32'd1);
    for (int k = 0; k < 6; k++) tick;
    #2;
    reset_n = 1'b0;
    #1;
    m_ctrl = '0;
    m_rd   = '0;
    m_pc4  = '0;
    m_res  = '0;
    m_wd   = '0;
    check("reset_mid.stall", {31'd0, stall}, 32'd0);
    check_outputs("reset_mid");
    @(negedge clk);
    reset_n = 1'b1;
    alu_step("post_reset_add", {1'b0, 3'd0, 4'd0, 2'b00, 5'b01010}, 32'd5, 32'd7, 32'd0);
    for (int i = 0; i < 36; i++)
      alu_step("post_reset_rand", rand_alu_ctrl() & 15'h3FFF, $urandom, $urandom, $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset_n  input  1  asynchronous active-low reset.
REQ-003 ctrl_ex  input  15  decoded control; [4:0] passes to ctrl_mem, [5] alu_src_b (1=imm), [6] alu_src_a (1=pc), [10:7] alu_op, [13:11] md funct3, [14] md_en.
REQ-004 rs1_data, rs2_data, imm, pc, pc4_ex, rd_ex  input  32 each  operands, immediate, pc, pc+4, destination (rd kept 32-bit as in MEM).
REQ-005 flush  input  1  kill current instruction (branch redirect).
REQ-006 stall  output  1  freeze ID/IF; combinational from FSM state.
REQ-007 ctrl_mem  output  5  registered ctrl_ex[4:0] or bubble 5'd0.
REQ-008 rd_mem, pc4_mem, alu_result, write_data1  output  32 each  registered rd, pc+4, result, rs2_data.

Function
REQ-009 Operand A SHALL be pc when alu_src_a=1, else rs1_data; B SHALL be imm when alu_src_b=1, else rs2_data.
REQ-010 alu_op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB; 11-15 SHALL yield 0; shifts use B[4:0]; SLT/SLTU yield 32'd0/32'd1; add/sub wrap modulo 2^32.
REQ-011 Non-md instruction: all outputs SHALL update on the next clk edge (1-cycle latency), stall=0.
REQ-012 md FSM states IDLE, RUN, DONE; IDLE->RUN when md_en=1 and flush=0; RUN counts 0..31 then ->DONE; DONE->IDLE unconditionally.
REQ-013 stall SHALL be 1 in IDLE while md_en=1 and flush=0, and throughout RUN; 0 in DONE and otherwise.
REQ-014 While stall=1 the output register SHALL load a bubble: ctrl_mem=0, other outputs hold their previous values.
REQ-015 In DONE the output register SHALL capture md result plus ctrl/rd/pc4/rs2 of the held instruction; md instruction presented in cycle N appears on outputs after the edge ending cycle N+33.
REQ-016 md funct3: 0 MUL low, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU; results per RV32M.
REQ-017 Divide by zero SHALL give quotient 32'hFFFFFFFF, remainder = dividend; DIV/REM of 32'h80000000 by -1 SHALL give quotient 32'h80000000, remainder 0; latency unchanged.
REQ-018 flush=1 SHALL load a bubble, force FSM to IDLE from any state and drop stall in the same cycle; flush has priority over md start and DONE capture.

Reset
REQ-019 reset_n=0 SHALL asynchronously clear ctrl_mem, rd_mem, pc4_mem, alu_result, write_data1 to 0, FSM to IDLE, counter to 0; stall=0 during reset.
REQ-020 Reset mid-RUN SHALL abandon the operation; no partial result reaches outputs.

Configuration
REQ-021 Macro RV32M_EN defined: md unit, FSM and stall present as above.
REQ-022 RV32M_EN undefined: md_en ignored, instruction executes as the ALU op in ctrl_ex[10:7], stall tied 0, no FSM/sub-module instantiated.

Structure
REQ-023 Shared package riscv_pkg SHALL hold alu_op codes, md funct3 codes, ctrl_ex bit-position constants and the FSM state typedef.
REQ-024 Iterative multiply/divide SHALL be sub-module muldiv_iter (start, funct3, a, b -> busy, done, result), instantiated only under RV32M_EN.

Verification
REQ-025 ADD rs1=5, rs2=7, ctrl_mem bits 5'b01010 -> next edge alu_result=12, ctrl_mem=5'b01010, write_data1=7.
REQ-026 SRA rs1=32'h80000000, imm=4, alu_src_b=1 -> alu_result=32'hF8000000; SLTU 1 vs 32'hFFFFFFFF -> 1.
REQ-027 MULH 32'hFFFFFFFF x 32'hFFFFFFFF -> stall high 33 cycles, bubbles on ctrl_mem, then alu_result=0 at edge N+33.
REQ-028 DIV 7 by 0 -> 32'hFFFFFFFF; REM 32'h80000000 by 32'hFFFFFFFF -> 0; DIVU 100 by 7 -> 14.
REQ-029 flush asserted at RUN count 10 -> stall=0 same cycle, ctrl_mem=0 next edge, following ADD completes with 1-cycle latency.
REQ-030 reset_n pulsed low mid-RUN -> all outputs 0 immediately, stall=0, FSM IDLE; build without RV32M_EN: MUL 3x4 yields ALU result, stall never 1.
